// File: rtl/gshare_update_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : gshare_update_scheduler_if
// Description : Bundles the resolved-branch input bus (from execute) and the
//               gshare predictor write port.
//                 res_*  : valid/ready record handshake (producer -> scheduler)
//                 pred_* : write strobe, PC, history, outcome (scheduler -> predictor)
//                 mispredict : pulse that accompanies a mispredicted write
//               master = execute/predictor side, slave = scheduler side.
// Revision    : 1.0 - initial release
// ============================================================================
interface gshare_update_scheduler_if #(
    parameter int HISTORY_LEN = 8
);
    logic                   res_valid;
    logic                   res_ready;
    logic [15:0]            res_pc;
    logic [HISTORY_LEN-1:0] res_history;
    logic                   res_taken;
    logic                   res_predicted;

    logic                   pred_write_enabled;
    logic [15:0]            pred_pc_bits_write;
    logic [HISTORY_LEN-1:0] pred_history_write;
    logic                   pred_outcome;
    logic                   mispredict;

    modport master (
        output res_valid, res_pc, res_history, res_taken, res_predicted,
        input  res_ready,
        input  pred_write_enabled, pred_pc_bits_write, pred_history_write,
        input  pred_outcome, mispredict
    );

    modport slave (
        input  res_valid, res_pc, res_history, res_taken, res_predicted,
        output res_ready,
        output pred_write_enabled, pred_pc_bits_write, pred_history_write,
        output pred_outcome, mispredict
    );
endinterface
`default_nettype wire

// File: rtl/gshare_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : gshare_update_scheduler
// Description : Buffers resolved-branch records in a small FIFO and drains
//               them in order, at most one per cycle, into the gshare
//               predictor write port. Draining can be frozen with hold.
//               Keeps saturating branch / misprediction counters.
// Ports       : clk, reset (async, active-low)
//               bus        : res_* record handshake in, pred_* write port out
//               hold       : freeze draining (enqueue still allowed)
//               stat_clear : synchronous clear of both statistics counters
//               fifo_count : occupied FIFO entries
//               busy       : entries pending or a write in flight
//               branch_count / mispredict_count : saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_update_scheduler #(
    parameter int HISTORY_LEN = 8,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    gshare_update_scheduler_if.slave   bus,
    input  logic                       hold,
    input  logic                       stat_clear,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy,
    output logic [15:0]                branch_count,
    output logic [15:0]                mispredict_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = 16 + HISTORY_LEN + 2;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    // Record layout: {pc, history, taken, predicted}
    logic [REC_W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       w_next_count;

    logic                   r_pred_we;
    logic [15:0]            r_pred_pc;
    logic [HISTORY_LEN-1:0] r_pred_hist;
    logic                   r_pred_outcome;
    logic                   r_mispredict;
    logic [15:0]            r_branch_count;
    logic [15:0]            r_mispredict_count;

    logic                   w_push;
    logic                   w_pop;
    logic [REC_W-1:0]       w_head;
    logic                   w_head_taken;
    logic                   w_head_pred;
    logic                   w_head_miss;

    // Ready depends only on the registered count: no pass-through when full.
    assign bus.res_ready = (r_count < C_DEPTH);
    assign w_push        = bus.res_valid && bus.res_ready;
    // The state register tracks occupancy exactly (IDLE <=> count == 0).
    assign w_pop         = (r_state != S_IDLE) && !hold;

    assign w_head        = r_mem[r_rd_ptr];
    assign w_head_taken  = w_head[1];
    assign w_head_pred   = w_head[0];
    assign w_head_miss   = w_head_taken ^ w_head_pred;

    always_comb begin
        w_next_count = r_count;
        if (w_push && !w_pop) begin
            w_next_count = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_next_count = r_count - CNT_W'(1);
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        if (w_next_count != '0) begin
            w_next_state = hold ? S_HELD : S_DRAIN;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.res_pc, bus.res_history, bus.res_taken, bus.res_predicted};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr           <= '0;
            r_rd_ptr           <= '0;
            r_count            <= '0;
            r_state            <= S_IDLE;
            r_pred_we          <= 1'b0;
            r_pred_pc          <= '0;
            r_pred_hist        <= '0;
            r_pred_outcome     <= 1'b0;
            r_mispredict       <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_count   <= w_next_count;
            r_state   <= w_next_state;
            r_pred_we <= w_pop;
            r_mispredict <= w_pop && w_head_miss;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr       <= r_rd_ptr + PTR_W'(1);
                r_pred_pc      <= w_head[REC_W-1 -: 16];
                r_pred_hist    <= w_head[HISTORY_LEN+1:2];
                r_pred_outcome <= w_head_taken;
            end

            // Clear wins over a coincident increment.
            if (stat_clear) begin
                r_branch_count     <= '0;
                r_mispredict_count <= '0;
            end else if (w_pop) begin
                if (r_branch_count != 16'hFFFF) begin
                    r_branch_count <= r_branch_count + 16'd1;
                end
                if (w_head_miss && (r_mispredict_count != 16'hFFFF)) begin
                    r_mispredict_count <= r_mispredict_count + 16'd1;
                end
            end
        end
    end

    assign bus.pred_write_enabled = r_pred_we;
    assign bus.pred_pc_bits_write = r_pred_pc;
    assign bus.pred_history_write = r_pred_hist;
    assign bus.pred_outcome       = r_pred_outcome;
    assign bus.mispredict         = r_mispredict;

    assign fifo_count       = r_count;
    assign busy             = (r_state != S_IDLE) || r_pred_we;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;
endmodule
`default_nettype wire

// File: tb/tb_gshare_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_update_scheduler
// Description : Bench for gshare_update_scheduler. A queue-based reference
//               model tracks accepted records, expected writes and counters;
//               a negedge monitor compares the DUT against it and pops the
//               scoreboard on every predictor write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_update_scheduler;
    localparam int HL    = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0]   pc;
        logic [HL-1:0] hist;
        logic          taken;
        logic          pred;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hold = 1'b0;
    logic        stat_clear = 1'b0;
    logic [2:0]  fifo_count;
    logic        busy;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    gshare_update_scheduler_if #(.HISTORY_LEN(HL)) bus ();

    gshare_update_scheduler #(.HISTORY_LEN(HL), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .hold             (hold),
        .stat_clear       (stat_clear),
        .fifo_count       (fifo_count),
        .busy             (busy),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    rec_t m_q[$];      // records held by the scheduler
    rec_t sb_q[$];     // expected predictor writes, in order
    bit   m_we = 1'b0;
    int   m_bc = 0;
    int   m_mc = 0;
    bit   mon_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    bit   md_pop, md_push;
    rec_t mh, mr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic rec_t mk(input logic [15:0] pc, input logic [HL-1:0] h,
                                input logic t, input logic p);
        rec_t r;
        r.pc = pc; r.hist = h; r.taken = t; r.pred = p;
        return r;
    endfunction

    function automatic rec_t rnd_rec();
        return mk(16'($urandom), HL'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endfunction

    // Model: FIFO of records; a non-empty FIFO with hold low produces one write.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            sb_q.delete();
            m_we = 1'b0;
            m_bc = 0;
            m_mc = 0;
        end else begin
            md_pop  = (m_q.size() > 0) && !hold;
            md_push = bus.res_valid && (m_q.size() < DEPTH);
            m_we    = md_pop;
            if (md_pop) mh = m_q.pop_front();
            if (stat_clear) begin
                m_bc = 0;
                m_mc = 0;
            end else if (md_pop) begin
                if (m_bc < 65535) m_bc++;
                if ((mh.taken != mh.pred) && (m_mc < 65535)) m_mc++;
            end
            if (md_push) begin
                mr = mk(bus.res_pc, bus.res_history, bus.res_taken, bus.res_predicted);
                m_q.push_back(mr);
                sb_q.push_back(mr);
            end
        end
    end

    // Monitor
    rec_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            check("write_enabled", 32'(bus.pred_write_enabled), 32'(m_we));
            check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
            check("res_ready", 32'(bus.res_ready), 32'(m_q.size() < DEPTH));
            check("busy", 32'(busy), 32'((m_q.size() != 0) || m_we));
            check("branch_count", 32'(branch_count), 32'(m_bc));
            check("mispredict_count", 32'(mispredict_count), 32'(m_mc));
            if (bus.pred_write_enabled) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: got pc %0h expected no write at %0t",
                             bus.pred_pc_bits_write, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_pc", 32'(bus.pred_pc_bits_write), 32'(e.pc));
                    check("wr_history", 32'(bus.pred_history_write), 32'(e.hist));
                    check("wr_outcome", 32'(bus.pred_outcome), 32'(e.taken));
                    check("wr_mispredict", 32'(bus.mispredict), 32'(e.taken ^ e.pred));
                end
            end else begin
                check("mispredict_idle", 32'(bus.mispredict), 32'd0);
            end
        end
    end

    // Driver: present a record at a negedge and hold it until accepted.
    task automatic push_rec(input rec_t r);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        bus.res_valid     = 1'b1;
        bus.res_pc        = r.pc;
        bus.res_history   = r.hist;
        bus.res_taken     = r.taken;
        bus.res_predicted = r.pred;
        while (!acc) begin
            acc = bus.res_ready;
            @(negedge clk);
            guard++;
            if (!acc && guard > 500) begin
                n_total++;
                $display("FAIL push_timeout: got no acceptance expected within 500 cycles");
                acc = 1'b1;
            end
        end
        bus.res_valid = 1'b0;
    endtask

    initial begin
        #3_000_000;
        n_total++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.res_valid = 1'b0;
        bus.res_pc = '0;
        bus.res_history = '0;
        bus.res_taken = 1'b0;
        bus.res_predicted = 1'b0;
        #2 reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_res_ready", 32'(bus.res_ready), 32'd1);
        check("rst_we", 32'(bus.pred_write_enabled), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single record with fixed contents
        push_rec(mk(16'h0104, 8'h3C, 1'b1, 1'b0));
        @(negedge clk);
        check("t1_we", 32'(bus.pred_write_enabled), 32'd1);
        check("t1_pc", 32'(bus.pred_pc_bits_write), 32'h0104);
        check("t1_hist", 32'(bus.pred_history_write), 32'h3C);
        check("t1_outcome", 32'(bus.pred_outcome), 32'd1);
        check("t1_mispredict", 32'(bus.mispredict), 32'd1);
        check("t1_branch_count", 32'(branch_count), 32'd1);
        check("t1_mispredict_count", 32'(mispredict_count), 32'd1);
        check("t1_fifo_count", 32'(fifo_count), 32'd0);
        @(negedge clk);

        // Clear while idle, then fill under hold with a fifth record waiting
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
        hold = 1'b1;
        fork
            for (int i = 0; i < 5; i++) push_rec(mk(16'h1000 + 16'(i), HL'(i), 1'(i), 1'b0));
            begin
                repeat (8) @(negedge clk);
                check("t2_fifo_full", 32'(fifo_count), 32'd4);
                check("t2_not_ready", 32'(bus.res_ready), 32'd0);
                check("t2_no_writes", 32'(branch_count), 32'd0);
                hold = 1'b0;
            end
        join
        repeat (8) @(negedge clk);
        check("t2_branch_count", 32'(branch_count), 32'd5);

        // Continuous stream, wraps pointers several times
        for (int i = 0; i < 20; i++) push_rec(rnd_rec());
        repeat (4) @(negedge clk);

        // Hold toggling with three queued records
        hold = 1'b1;
        for (int i = 0; i < 3; i++) push_rec(mk(16'h2000 + 16'(i), 8'hA0, 1'b1, 1'(i)));
        for (int i = 0; i < 8; i++) begin
            hold = (i % 2 == 0);
            @(negedge clk);
        end
        hold = 1'b0;
        repeat (4) @(negedge clk);

        // Randomised traffic with hold and stat_clear noise
        fork
            for (int i = 0; i < 80; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push_rec(rnd_rec());
            end
            begin
                for (int i = 0; i < 250; i++) begin
                    hold       = ($urandom_range(0, 3) == 0);
                    stat_clear = ($urandom_range(0, 19) == 0);
                    @(negedge clk);
                end
                hold = 1'b0;
                stat_clear = 1'b0;
            end
        join
        repeat (6) @(negedge clk);

        // Reset mid-stream with a write in flight and three entries left
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push_rec(rnd_rec());
        hold = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_we_drop", 32'(bus.pred_write_enabled), 32'd0);
        check("t5_fifo_count", 32'(fifo_count), 32'd0);
        check("t5_res_ready", 32'(bus.res_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_no_write_after", 32'(branch_count), 32'd0);
        push_rec(mk(16'h5555, 8'h55, 1'b0, 1'b0));
        repeat (3) @(negedge clk);

        // Saturation of branch_count, then clear coincident with a write
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
        for (int i = 0; i < 65540; i++) push_rec(rnd_rec());
        repeat (3) @(negedge clk);
        check("t4_saturated", 32'(branch_count), 32'hFFFF);
        fork
            for (int i = 0; i < 8; i++) push_rec(rnd_rec());
            begin
                repeat (3) @(negedge clk);
                stat_clear = 1'b1;
                @(negedge clk);
                stat_clear = 1'b0;
                check("t4_clear_we", 32'(bus.pred_write_enabled), 32'd1);
                check("t4_clear_bc", 32'(branch_count), 32'd0);
                check("t4_clear_mc", 32'(mispredict_count), 32'd0);
            end
        join
        repeat (6) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/gshare_update_scheduler.md
Name: gshare_update_scheduler

Overview:
- Buffers resolved-branch records from execute and drains them, one per cycle, into the write/update port of the gshare predictor.
- Each record carries PC, history snapshot, outcome and prediction.
- Enforces ordered, single-write-per-cycle updates of the predictor's shared history register and pattern table.
- Freezes updates during pipeline flush and keeps branch/misprediction statistics.

Parameters:
HISTORY_LEN, 8, width of the global history snapshot; must match the predictor.
DEPTH, 4, number of record FIFO entries; power of two, at least 2.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
res_valid  in  1  execute presents a resolved branch record.
res_ready  out  1  scheduler can accept a record this cycle.
res_pc  in  16  branch PC.
res_history  in  HISTORY_LEN  history value captured at fetch for this branch.
res_taken  in  1  actual outcome, 1 = taken.
res_predicted  in  1  prediction made at fetch.
hold  in  1  freeze draining; enqueue still allowed.
stat_clear  in  1  synchronous clear of both statistics counters.
pred_write_enabled  out  1  write strobe to the predictor.
pred_pc_bits_write  out  16  PC to the predictor write port.
pred_history_write  out  HISTORY_LEN  history to the predictor write port.
pred_outcome  out  1  outcome to the predictor.
mispredict  out  1  one-cycle pulse, coincident with a write whose record had res_taken != res_predicted.
fifo_count  out  $clog2(DEPTH)+1  number of occupied entries.
busy  out  1  high when fifo_count != 0 or pred_write_enabled is high.
branch_count  out  16  writes issued since reset or clear; saturating.
mispredict_count  out  16  mispredict pulses since reset or clear; saturating.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO empty; read/write pointers 0.
  - All outputs 0 except res_ready = 1.
  - State IDLE.
  - Counters 0.
- Enqueue:
  - Occurs on a rising edge with res_valid && res_ready.
  - Writes {pc, history, taken, predicted} at the write pointer; the pointer wraps modulo DEPTH.
- res_ready = (fifo_count < DEPTH), combinational from registered count only.
  - There is no pass-through when full, even if a dequeue happens the same cycle.
  - res_valid while full is ignored; the record is not lost, because the producer must hold it.
- FSM, one registered state:
  - IDLE: count == 0.
  - DRAIN: count > 0 && !hold.
  - HELD: count > 0 && hold.
  - Transitions are evaluated each edge from next count and hold.
  - An IDLE -> HELD edge is legal if hold is asserted while the first entry arrives.
- Dequeue:
  - On an edge where the current count > 0 and hold == 0, the head entry is popped.
  - On that same edge, the pred_* outputs are registered from the head with pred_write_enabled = 1.
  - On any other edge, pred_write_enabled = 0; pred_* data keeps its last value.
  - At most one write per cycle.
- Latency:
  - A record enqueued at edge N into an empty FIFO with hold low appears on pred_* (write_enabled = 1) after edge N+1.
  - Back-to-back records sustain one write per cycle.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- hold:
  - Sampled each edge; blocks the dequeue on that edge only.
  - A write already registered completes its single cycle.
  - Order is always preserved (FIFO).
- mispredict is registered together with pred_write_enabled: head.taken XOR head.predicted, gated by the write.
- Counters:
  - On a write, branch_count += 1 and, if mispredict, mispredict_count += 1.
  - Both saturate at 16'hFFFF with no wrap.
  - stat_clear has priority: counters become 0 on that edge and the coincident increment is discarded.
  - stat_clear does not affect the FIFO or writes.
- Reset mid-operation:
  - Pending records are discarded.
  - pred_write_enabled drops immediately (asynchronous).
  - No partial write is reissued after release.
- Pointer wrap uses DEPTH-1 masks; count is tracked separately, so full (count == DEPTH) and empty (count == 0) are unambiguous.

Test Plan:
1. Reset release, single record pc=16'h0104, history=8'h3C, taken=1, predicted=0, hold=0:
   - Edge after enqueue: pred_write_enabled=1, pred_pc_bits_write=16'h0104, pred_history_write=8'h3C, pred_outcome=1, mispredict=1.
   - Afterwards: branch_count=1, mispredict_count=1, fifo_count=0.
2. hold=1, push 5 records with DEPTH=4:
   - After 4 accepted, res_ready=0 and fifo_count=4; the 5th is held by the producer.
   - No writes occur.
   - Release hold: 4 consecutive writes in push order, then the 5th; branch_count=5.
3. Continuous res_valid every cycle, hold=0:
   - One write per cycle, fifo_count steady at 1, in order.
   - Verifies simultaneous enqueue/dequeue and pointer wrap past DEPTH.
4. Preload branch_count to 16'hFFFF via 65535 writes (or force), then 1 more write: count stays 16'hFFFF.
   - stat_clear coincident with a write: both counters read 0 next cycle.
5. Assert reset low mid-stream with fifo_count=3:
   - pred_write_enabled=0 immediately, fifo_count=0, res_ready=1.
   - No writes after release until a new enqueue.
6. hold toggled 1-0-1-0 with 3 queued records: writes occur only on edges sampling hold=0; mispredict pulses only on those writes; order is preserved.
